// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter and decode hazard logic:
// default widths and the starvation FSM encoding.
package rf_writeback_arbiter_pkg;

   localparam int unsigned DEF_DATA_WIDTH   = 32;
   localparam int unsigned DEF_ADDR_WIDTH   = 5;
   localparam int unsigned DEF_STARVE_LIMIT = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FORCE = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rf_writeback_arbiter_scoreboard.sv
// Pending-write scoreboard for long-latency destinations: one busy bit per register,
// x0 never busy, set wins over a same-cycle clear of the same register.
module rf_writeback_arbiter_scoreboard
   import rf_writeback_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  set_en_i,
   input  logic [ADDR_WIDTH-1:0] set_addr_i,
   input  logic                  clr_en_i,
   input  logic [ADDR_WIDTH-1:0] clr_addr_i,
   input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
   input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
   input  logic [ADDR_WIDTH-1:0] rs3_addr_i,
   output logic                  rs1_busy_o,
   output logic                  rs2_busy_o,
   output logic                  rs3_busy_o
);

   localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   // NOTE: clear is applied before set so that a same-cycle set of the same register wins.
   always_comb begin
      busy_d = busy_q;
      if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
      if (set_en_i) busy_d[set_addr_i] = 1'b1;
      busy_d[0] = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments; reset is synchronous and
   // clears the whole vector since it is only 2**ADDR_WIDTH flops, not a RAM.
   always_ff @(posedge clk_i) begin
      if (reset_i) busy_q <= '0;
      else         busy_q <= busy_d;
   end

   assign rs1_busy_o = busy_q[rs1_addr_i];
   assign rs2_busy_o = busy_q[rs2_addr_i];
   assign rs3_busy_o = busy_q[rs3_addr_i];

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Shares the single register-file write port between pipeline writeback and the
// long-latency unit, with starvation forcing and a busy-register hazard stall.
module rf_writeback_arbiter
   import rf_writeback_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  pipe_we_i,
   input  logic [ADDR_WIDTH-1:0] pipe_rd_i,
   input  logic [DATA_WIDTH-1:0] pipe_data_i,
   input  logic                  ll_valid_i,
   input  logic [ADDR_WIDTH-1:0] ll_rd_i,
   input  logic [DATA_WIDTH-1:0] ll_data_i,
   output logic                  ll_ready_o,
   input  logic                  issue_valid_i,
   input  logic [ADDR_WIDTH-1:0] issue_rd_i,
   input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
   input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
   output logic                  hazard_stall_o,
   output logic                  pipe_hold_o,
   output logic                  rf_write_o,
   output logic [ADDR_WIDTH-1:0] rf_inaddress_o,
   output logic [DATA_WIDTH-1:0] rf_in_o
);

   localparam int unsigned           CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_WIDTH-1:0]  CNT_LIMIT = CNT_WIDTH'(STARVE_LIMIT);

   arb_state_e           state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   logic pipe_req;
   logic force_st;
   logic grant_pipe;
   logic grant_ll;
   logic ll_hs;
   logic rs1_busy, rs2_busy, issue_busy;
   logic issue_accept;

   // A pipe write to x0 is not a real request and never blocks the LL unit.
   assign pipe_req   = pipe_we_i & (pipe_rd_i != '0);
   assign force_st   = (state_q == ST_FORCE);
   assign grant_pipe = pipe_req & ~force_st;
   assign grant_ll   = ll_valid_i & (force_st | ~pipe_req);
   assign ll_hs      = grant_ll & ~reset_i;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (ll_valid_i && pipe_req) begin
               state_d = ST_WAIT;
               cnt_d   = CNT_WIDTH'(1);
            end
         end
         ST_WAIT: begin
            if (ll_valid_i && pipe_req) begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
               if (cnt_d >= CNT_LIMIT) state_d = ST_FORCE;
            end else begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      rf_write_o     = 1'b0;
      rf_inaddress_o = '0;
      rf_in_o        = '0;
      if (grant_pipe) begin
         rf_write_o     = 1'b1;
         rf_inaddress_o = pipe_rd_i;
         rf_in_o        = pipe_data_i;
      end else if (grant_ll) begin
         rf_write_o     = (ll_rd_i != '0);
         rf_inaddress_o = ll_rd_i;
         rf_in_o        = ll_data_i;
      end
      if (reset_i) begin
         rf_write_o     = 1'b0;
         rf_inaddress_o = '0;
         rf_in_o        = '0;
      end
   end

   assign ll_ready_o  = ll_hs;
   assign pipe_hold_o = force_st & ~reset_i;

   // Issue is refused while its destination is still pending; decode stalls instead.
   assign issue_accept = issue_valid_i & ~issue_busy;

   rf_writeback_arbiter_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_scoreboard (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .set_en_i   (issue_accept),
      .set_addr_i (issue_rd_i),
      .clr_en_i   (ll_hs),
      .clr_addr_i (ll_rd_i),
      .rs1_addr_i (rs1_addr_i),
      .rs2_addr_i (rs2_addr_i),
      .rs3_addr_i (issue_rd_i),
      .rs1_busy_o (rs1_busy),
      .rs2_busy_o (rs2_busy),
      .rs3_busy_o (issue_busy)
   );

   assign hazard_stall_o = (rs1_busy | rs2_busy | (issue_valid_i & issue_busy)) & ~reset_i;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter with a small register-file model on the write port.
module tb_rf_writeback_arbiter;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        pipe_we_i;
   logic [4:0]  pipe_rd_i;
   logic [31:0] pipe_data_i;
   logic        ll_valid_i;
   logic [4:0]  ll_rd_i;
   logic [31:0] ll_data_i;
   logic        ll_ready_o;
   logic        issue_valid_i;
   logic [4:0]  issue_rd_i;
   logic [4:0]  rs1_addr_i;
   logic [4:0]  rs2_addr_i;
   logic        hazard_stall_o;
   logic        pipe_hold_o;
   logic        rf_write_o;
   logic [4:0]  rf_inaddress_o;
   logic [31:0] rf_in_o;

   logic [31:0] rf_mem [32];
   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   rf_writeback_arbiter dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .pipe_we_i      (pipe_we_i),
      .pipe_rd_i      (pipe_rd_i),
      .pipe_data_i    (pipe_data_i),
      .ll_valid_i     (ll_valid_i),
      .ll_rd_i        (ll_rd_i),
      .ll_data_i      (ll_data_i),
      .ll_ready_o     (ll_ready_o),
      .issue_valid_i  (issue_valid_i),
      .issue_rd_i     (issue_rd_i),
      .rs1_addr_i     (rs1_addr_i),
      .rs2_addr_i     (rs2_addr_i),
      .hazard_stall_o (hazard_stall_o),
      .pipe_hold_o    (pipe_hold_o),
      .rf_write_o     (rf_write_o),
      .rf_inaddress_o (rf_inaddress_o),
      .rf_in_o        (rf_in_o)
   );

   // Register file model: commits at the posedge after the write is presented.
   always @(posedge clk_i) begin
      if (rf_write_o) rf_mem[rf_inaddress_o] <= rf_in_o;
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf_mem[i] = '0;
      reset_i = 1'b1;
      pipe_we_i = 1'b0; pipe_rd_i = '0; pipe_data_i = '0;
      ll_valid_i = 1'b0; ll_rd_i = '0; ll_data_i = '0;
      issue_valid_i = 1'b0; issue_rd_i = '0;
      rs1_addr_i = '0; rs2_addr_i = '0;
      step();
      step();

      // Reset state: requests present but all outputs held low
      pipe_we_i = 1'b1; pipe_rd_i = 5'd3; pipe_data_i = 32'h1234;
      ll_valid_i = 1'b1; ll_rd_i = 5'd4;
      #1;
      check("rst_rf_write", 32'(rf_write_o), 32'd0);
      check("rst_ll_ready", 32'(ll_ready_o), 32'd0);
      check("rst_addr", 32'(rf_inaddress_o), 32'd0);
      step();
      reset_i = 1'b0;
      pipe_we_i = 1'b0; ll_valid_i = 1'b0;

      // 1: plain pipeline write
      pipe_we_i = 1'b1; pipe_rd_i = 5'd5; pipe_data_i = 32'hA5;
      #1;
      check("t1_rf_write", 32'(rf_write_o), 32'd1);
      check("t1_addr", 32'(rf_inaddress_o), 32'd5);
      check("t1_data", rf_in_o, 32'hA5);
      check("t1_ll_ready", 32'(ll_ready_o), 32'd0);
      check("t1_hold", 32'(pipe_hold_o), 32'd0);
      step();
      pipe_we_i = 1'b0;
      check("t1_x5", rf_mem[5], 32'hA5);

      // 2: LL starved for 4 cycles, forced on the 5th
      pipe_we_i = 1'b1; pipe_rd_i = 5'd6; pipe_data_i = 32'h66;
      ll_valid_i = 1'b1; ll_rd_i = 5'd7; ll_data_i = 32'h77;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("t2_ready_c%0d", i), 32'(ll_ready_o), 32'd0);
         check($sformatf("t2_addr_c%0d", i), 32'(rf_inaddress_o), 32'd6);
         check($sformatf("t2_hold_c%0d", i), 32'(pipe_hold_o), 32'd0);
         step();
      end
      #1;
      check("t2_force_hold", 32'(pipe_hold_o), 32'd1);
      check("t2_force_ready", 32'(ll_ready_o), 32'd1);
      check("t2_force_write", 32'(rf_write_o), 32'd1);
      check("t2_force_addr", 32'(rf_inaddress_o), 32'd7);
      check("t2_force_data", rf_in_o, 32'h77);
      step();
      ll_valid_i = 1'b0;
      #1;
      check("t2_after_hold", 32'(pipe_hold_o), 32'd0);
      check("t2_after_addr", 32'(rf_inaddress_o), 32'd6);
      check("t2_after_write", 32'(rf_write_o), 32'd1);
      step();
      pipe_we_i = 1'b0;
      check("t2_x7", rf_mem[7], 32'h77);
      check("t2_x6", rf_mem[6], 32'h66);

      // 3: issue to x9, dependent read stalls until the cycle after the LL write
      issue_valid_i = 1'b1; issue_rd_i = 5'd9;
      #1;
      check("t3_issue_nostall", 32'(hazard_stall_o), 32'd0);
      step();
      issue_valid_i = 1'b0; rs1_addr_i = 5'd9;
      #1;
      check("t3_rs1_stall", 32'(hazard_stall_o), 32'd1);
      step();
      rs1_addr_i = 5'd0; rs2_addr_i = 5'd9;
      #1;
      check("t3_rs2_stall", 32'(hazard_stall_o), 32'd1);
      step();
      rs2_addr_i = 5'd0; issue_valid_i = 1'b1; issue_rd_i = 5'd9;
      #1;
      check("t3_issue_busy_stall", 32'(hazard_stall_o), 32'd1);
      step();
      issue_valid_i = 1'b0; rs1_addr_i = 5'd9;
      ll_valid_i = 1'b1; ll_rd_i = 5'd9; ll_data_i = 32'h99;
      #1;
      check("t3_ll_ready", 32'(ll_ready_o), 32'd1);
      check("t3_stall_during_wb", 32'(hazard_stall_o), 32'd1);
      step();
      ll_valid_i = 1'b0;
      #1;
      check("t3_released", 32'(hazard_stall_o), 32'd0);
      check("t3_x9", rf_mem[9], 32'h99);

      // 4: same-cycle LL handshake and accepted issue on x9: set wins
      rs1_addr_i = 5'd0;
      ll_valid_i = 1'b1; ll_rd_i = 5'd9; ll_data_i = 32'h5A;
      issue_valid_i = 1'b1; issue_rd_i = 5'd9;
      #1;
      check("t4_ll_ready", 32'(ll_ready_o), 32'd1);
      check("t4_no_stall", 32'(hazard_stall_o), 32'd0);
      step();
      ll_valid_i = 1'b0; issue_valid_i = 1'b0; rs1_addr_i = 5'd9;
      #1;
      check("t4_still_busy", 32'(hazard_stall_o), 32'd1);
      ll_valid_i = 1'b1; ll_data_i = 32'h5B;
      step();
      ll_valid_i = 1'b0;
      #1;
      check("t4_cleared", 32'(hazard_stall_o), 32'd0);
      rs1_addr_i = 5'd0;

      // 5: x0 destinations: pipe rd=0 does not block LL, nothing written, x0 never busy
      pipe_we_i = 1'b1; pipe_rd_i = 5'd0; pipe_data_i = 32'hFF;
      ll_valid_i = 1'b1; ll_rd_i = 5'd0; ll_data_i = 32'h33;
      issue_valid_i = 1'b1; issue_rd_i = 5'd0;
      #1;
      check("t5_ll_ready", 32'(ll_ready_o), 32'd1);
      check("t5_rf_write", 32'(rf_write_o), 32'd0);
      check("t5_hold", 32'(pipe_hold_o), 32'd0);
      check("t5_stall", 32'(hazard_stall_o), 32'd0);
      step();
      ll_valid_i = 1'b0;
      #1;
      check("t5_stall_x0", 32'(hazard_stall_o), 32'd0);
      check("t5_rf_write_pipe0", 32'(rf_write_o), 32'd0);
      step();
      pipe_we_i = 1'b0; issue_valid_i = 1'b0;

      // 6: reset in WAIT with x3 busy
      issue_valid_i = 1'b1; issue_rd_i = 5'd3;
      step();
      issue_valid_i = 1'b0; rs1_addr_i = 5'd3;
      pipe_we_i = 1'b1; pipe_rd_i = 5'd2; pipe_data_i = 32'h22;
      ll_valid_i = 1'b1; ll_rd_i = 5'd8; ll_data_i = 32'h88;
      #1;
      check("t6_pre_stall", 32'(hazard_stall_o), 32'd1);
      step();
      step();
      reset_i = 1'b1;
      #1;
      check("t6_rst_write", 32'(rf_write_o), 32'd0);
      check("t6_rst_ready", 32'(ll_ready_o), 32'd0);
      check("t6_rst_hold", 32'(pipe_hold_o), 32'd0);
      check("t6_rst_stall", 32'(hazard_stall_o), 32'd0);
      check("t6_rst_addr", 32'(rf_inaddress_o), 32'd0);
      check("t6_rst_data", rf_in_o, 32'd0);
      step();
      reset_i = 1'b0;
      #1;
      check("t6_busy_cleared", 32'(hazard_stall_o), 32'd0);
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("t6_ready_c%0d", i), 32'(ll_ready_o), 32'd0);
         check($sformatf("t6_hold_c%0d", i), 32'(pipe_hold_o), 32'd0);
         step();
      end
      #1;
      check("t6_force_hold", 32'(pipe_hold_o), 32'd1);
      check("t6_force_addr", 32'(rf_inaddress_o), 32'd8);
      step();
      pipe_we_i = 1'b0; ll_valid_i = 1'b0; rs1_addr_i = 5'd0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
